fill_arbiter: RTL



---
 rtl/fill_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/fill_arbiter.sv
// rtl/fill_arbiter.sv - two-channel round-robin fill valve arbiter
// Min on-time, fairness timeout, dead-time gap and latched per-valve fault lockout.
module fill_arbiter #(
    parameter int MIN_ON = 16,
    parameter int MAX_ON = 64,
    parameter int GAP    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] A,
    input  logic [1:0] P,
    input  logic       clr,
    output logic [1:0] C,
    output logic [1:0] Pout
);

    localparam int CW = $clog2(MAX_ON + 1);
    localparam int GW = $clog2(GAP + 1);
    localparam logic [CW-1:0] MIN_LAST = CW'(MIN_ON - 1);
    localparam logic [CW-1:0] MAX_LAST = CW'(MAX_ON - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(MAX_ON);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [GW-1:0] gcnt;
    logic          last;

    logic [1:0] elig;
    logic       cur;
    logic       exit_grant;

    // cur selects the held channel; only meaningful in the grant states
    always_comb begin
        elig       = A & ~Pout;
        cur        = (state == S_GRANT1);
        exit_grant = P[cur]
                   || ((cnt >= MIN_LAST) && !A[cur])
                   || ((cnt >= MAX_LAST) && elig[~cur]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            C     <= 2'b00;
            Pout  <= 2'b00;
            cnt   <= '0;
            gcnt  <= '0;
            last  <= 1'b1;
        end else begin
            // a fault sampled alongside clr wins, so the flag stays set
            Pout <= P | (Pout & ~{2{clr}});

            case (state)
                S_IDLE: begin
                    C <= 2'b00;
                    if (elig[0] && (!elig[1] || last)) begin
                        state <= S_GRANT0;
                        C     <= 2'b01;
                        cnt   <= '0;
                        last  <= 1'b0;
                    end else if (elig[1]) begin
                        state <= S_GRANT1;
                        C     <= 2'b10;
                        cnt   <= '0;
                        last  <= 1'b1;
                    end
                end
                S_GRANT0, S_GRANT1: begin
                    if (exit_grant) begin
                        state <= S_GAP;
                        C     <= 2'b00;
                        gcnt  <= '0;
                    end else if (cnt != CNT_SAT) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    C <= 2'b00;
                    if (gcnt == GAP_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    C     <= 2'b00;
                end
            endcase
        end
    end

endmodule
